// File: rtl/matmul_ip_pkg.sv
// matmul_ip_pkg: shared state encoding, CON bit map and element counts for the matmul IP sequencer.
package matmul_ip_pkg;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READ  = 3'd4;
  localparam logic [2:0] ST_CLEAR = 3'd5;
  localparam int CON_RD    = 8;
  localparam int CON_ROW   = 6;
  localparam int CON_COL   = 4;
  localparam int CON_START = 2;
  localparam int CON_INIT  = 1;
  localparam int CON_MODE  = 0;
  localparam int N_ELEM_4X4 = 16;
  localparam int N_ELEM_3X3 = 9;
  localparam int N_BEATS    = 8;
  function automatic logic [1:0] dim_last(input logic m);
    return m ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/seq_operand_buf.sv
// seq_operand_buf: 8x16 operand buffer, written in beat order and read by index.
module seq_operand_buf (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  raddr,
  output logic [15:0] rdata
);
  logic [7:0][15:0] mem;
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) mem <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/matmul_ip_sequencer.sv
// matmul_ip_sequencer: loads A/B operand beats, streams them to the accelerator, waits, then reads C back row-major.
module matmul_ip_sequencer
  import matmul_ip_pkg::*;
#(
  parameter int WAIT_CYCLES = 16,
  parameter int CLR_CYCLES  = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_mode,
  input  logic        clr_req,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [1:0]  res_row,
  output logic [1:0]  res_col,
  output logic        res_last,
  output logic [31:0] IPIN,
  output logic [31:0] CON,
  input  logic [31:0] IPOUT
);
  localparam int CW_A = $clog2(WAIT_CYCLES) > 3 ? $clog2(WAIT_CYCLES) : 3;
  localparam int CW   = $clog2(CLR_CYCLES) > CW_A ? $clog2(CLR_CYCLES) : CW_A;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_CYCLES - 1);
  localparam logic [2:0]    BEAT_LAST = 3'(N_BEATS - 1);
  if (WAIT_CYCLES < 14) begin : g_bad_wait
    $error("WAIT_CYCLES must be >= 14");
  end
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          mode;
  logic [1:0]    row, col;
  logic [3:0]    ecnt;
  logic [15:0]   buf_rdata;
  logic [3:0]    last_e;
  logic          beat_ok;
  assign last_e   = mode ? 4'(N_ELEM_3X3 - 1) : 4'(N_ELEM_4X4 - 1);
  assign in_ready = RSTN && ((state == ST_IDLE && !clr_req) || state == ST_LOAD);
  assign beat_ok  = in_valid && in_ready;
  assign busy     = state != ST_IDLE;
  assign IPIN     = state == ST_SEND ? {16'b0, buf_rdata} : 32'd0;
  seq_operand_buf u_buf (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .we    (beat_ok),
    .waddr (cnt[2:0]),
    .wdata (in_data),
    .raddr (cnt[2:0]),
    .rdata (buf_rdata)
  );
  always_comb begin
    CON = '0;
    CON[CON_START]    = state == ST_SEND;
    CON[CON_INIT]     = state == ST_CLEAR;
    CON[CON_RD]       = state == ST_READ;
    CON[CON_ROW +: 2] = state == ST_READ ? row : 2'd0;
    CON[CON_COL +: 2] = state == ST_READ ? col : 2'd0;
    CON[CON_MODE]     = state != ST_IDLE && state != ST_LOAD && mode;
  end
  // READ alternates: capture IPOUT while res_valid is low, then hold until the handshake.
  always_ff @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      row       <= 2'd0;
      col       <= 2'd0;
      ecnt      <= 4'd0;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_row   <= 2'd0;
      res_col   <= 2'd0;
      res_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE:
          if (clr_req) begin
            state <= ST_CLEAR;
            mode  <= in_mode;
            cnt   <= '0;
          end else if (in_valid) begin
            state <= ST_LOAD;
            mode  <= in_mode;
            cnt   <= CW'(1);
          end
        ST_LOAD:
          if (in_valid) begin
            cnt <= cnt + 1'b1;
            if (cnt[2:0] == BEAT_LAST) begin
              state <= ST_SEND;
              cnt   <= '0;
            end
          end
        ST_SEND: begin
          cnt <= cnt + 1'b1;
          if (cnt[2:0] == BEAT_LAST) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == WAIT_LAST) begin
            state <= ST_READ;
            cnt   <= '0;
            row   <= 2'd0;
            col   <= 2'd0;
            ecnt  <= 4'd0;
          end
        end
        ST_READ:
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_data  <= IPOUT;
            res_row   <= row;
            res_col   <= col;
            res_last  <= ecnt == last_e;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            ecnt      <= ecnt + 4'd1;
            col       <= col == dim_last(mode) ? 2'd0 : col + 2'd1;
            row       <= col == dim_last(mode) ? row + 2'd1 : row;
            if (res_last) state <= ST_IDLE;
          end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == CLR_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_matmul_ip_sequencer.sv
// tb_matmul_ip_sequencer: table-driven operations against a behavioural accelerator, results checked through a scoreboard queue.
module tb_matmul_ip_sequencer;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = 16'd0;
  logic        in_mode = 1'b0;
  logic        clr_req = 1'b0;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic [1:0]  res_row, res_col;
  logic        res_last;
  logic [31:0] IPIN, CON, IPOUT;

  typedef struct {
    logic             mode;
    logic [7:0][15:0] beats;
    logic [3:0][31:0] exp_col;
    bit               stall;
  } vec_t;
  typedef struct {
    logic [1:0]  r, c;
    logic [31:0] d;
    logic        l;
  } exp_t;

  vec_t  vt[4];
  exp_t  q[$];
  exp_t  e;
  int    n_vec = 0, n_err = 0, popped = 0;
  logic  cur_mode = 1'b0;
  bit    live = 1'b0;
  logic [15:0] w[8];
  int    k = 0, gap = 0;
  bit    armed = 1'b0;

  matmul_ip_sequencer dut (
    .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .clr_req(clr_req), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col), .res_last(res_last),
    .IPIN(IPIN), .CON(CON), .IPOUT(IPOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Accelerator: collects the 8 words of a start burst, zeroes row/col 3 in 3x3 mode, returns C combinationally.
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) k <= 0;
    else if (CON[2]) begin
      w[k[2:0]] <= IPIN[15:0];
      k <= k + 1;
    end else begin
      if (k != 0) chk("send_len", 32'(k), 32'd8);
      k <= 0;
    end

  always_comb begin
    int acc;
    logic signed [3:0] ea, eb;
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      ea = w[{1'b0, CON[7:6]}][{j[1:0], 2'b00} +: 4];
      eb = w[4 + j][{CON[5:4], 2'b00} +: 4];
      if (!(CON[0] && (CON[7:6] == 2'd3 || CON[5:4] == 2'd3 || j == 3)))
        acc = acc + int'(ea) * int'(eb);
    end
    IPOUT = CON[8] ? 32'(acc) : 32'd0;
  end

  always @(negedge CLK) begin
    if (!RSTN) armed = 1'b0;
    else if (live) begin
      if (!busy) chk("idle_con", CON, 32'd0);
      if (CON[2] || CON[8]) chk("con_mode", 32'(CON[0]), 32'(cur_mode));
      if (CON[8] && cur_mode) chk("rd_idx3", 32'(CON[7:6] == 2'd3 || CON[5:4] == 2'd3), 32'd0);
      if (!CON[2]) chk("ipin_idle", IPIN, 32'd0);
      if (CON[2]) begin
        armed = 1'b1;
        gap = 0;
      end else if (armed && CON[8]) begin
        chk("wait_len", 32'(gap), 32'd16);
        armed = 1'b0;
      end else if (armed) gap++;
      if (res_valid && res_ready) begin
        if (q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("res_data", res_data, e.d);
          chk("res_row", 32'(res_row), 32'(e.r));
          chk("res_col", 32'(res_col), 32'(e.c));
          chk("res_last", 32'(res_last), 32'(e.l));
          popped++;
        end
      end
    end
  end

  task automatic run_op(input vec_t v, input bit abort);
    int n, sc, t;
    bit stalled, done;
    logic [31:0] sd;
    logic [1:0] sr, scl;
    logic [3:0] scon;
    n = v.mode ? 3 : 4;
    cur_mode = v.mode;
    popped = 0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        q.push_back('{2'(r), 2'(c), v.exp_col[c], r == n - 1 && c == n - 1});
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data = v.beats[b];
      in_mode = b == 0 ? v.mode : ~v.mode;
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge CLK); #1;
        t++;
      end
      if (t == 50) chk("beat_timeout", 32'd1, 32'd0);
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    sc = 0;
    stalled = 0;
    done = 0;
    for (t = 0; t < 1000; t++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      if (abort && CON[2]) begin
        if (sc == 3) begin
          RSTN = 1'b0;
          #1;
          chk("abort_con", CON, 32'd0);
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_ready", 32'(in_ready), 32'd0);
          chk("abort_ipin", IPIN, 32'd0);
          repeat (2) @(posedge CLK);
          #1 RSTN = 1'b1;
          q.delete();
          return;
        end
        sc++;
      end
      if (v.stall && !stalled && res_valid && popped == 4) begin
        res_ready = 1'b0;
        sd = res_data;
        sr = res_row;
        scl = res_col;
        scon = CON[7:4];
        repeat (5) begin
          @(negedge CLK);
          chk("stall_valid", 32'(res_valid), 32'd1);
          chk("stall_data", res_data, sd);
          chk("stall_row", 32'(res_row), 32'(sr));
          chk("stall_col", 32'(res_col), 32'(scl));
          chk("stall_con", 32'(CON[7:4]), 32'(scon));
        end
        @(posedge CLK); #1;
        res_ready = 1'b1;
        stalled = 1;
      end
      @(posedge CLK); #1;
    end
    chk("op_done", 32'(done), 32'd1);
    chk("sb_empty", 32'(q.size()), 32'd0);
    chk("beat_count", 32'(popped), 32'(n * n));
    if (v.stall) chk("stall_seen", 32'(stalled), 32'd1);
  endtask

  initial begin
    int nclr;
    vt[0] = '{1'b0, {16'h4321, 16'h4321, 16'h4321, 16'h4321, 16'h1000, 16'h0100, 16'h0010, 16'h0001},
              {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0};
    vt[1] = '{1'b1, {8{16'h1111}}, {32'd0, 32'd3, 32'd3, 32'd3}, 1'b0};
    vt[2] = '{1'b0, {{4{16'h7777}}, {4{16'h8888}}}, {4{32'hFFFFFF20}}, 1'b0};
    vt[3] = vt[0];
    vt[3].stall = 1'b1;
    #2 RSTN = 1'b0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_con", CON, 32'd0);
    chk("rst_ipin", IPIN, 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_last", 32'(res_last), 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_rowcol", 32'({res_row, res_col}), 32'd0);
    repeat (3) @(posedge CLK);
    #1 RSTN = 1'b1;
    live = 1'b1;
    @(posedge CLK); #1;
    for (int i = 0; i < 4; i++) run_op(vt[i], 1'b0);
    run_op(vt[0], 1'b1);
    @(posedge CLK); #1;
    clr_req = 1'b1;
    in_valid = 1'b1;
    in_mode = 1'b1;
    in_data = 16'hdead;
    #1 chk("clr_prio_ready", 32'(in_ready), 32'd0);
    @(posedge CLK); #1;
    clr_req = 1'b0;
    in_valid = 1'b0;
    in_mode = 1'b0;
    nclr = 0;
    repeat (6) begin
      @(negedge CLK);
      if (CON[1]) begin
        nclr++;
        chk("clr_mode", 32'(CON[0]), 32'd1);
      end
    end
    chk("clr_len", 32'(nclr), 32'd2);
    chk("clr_idle", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    run_op(vt[0], 1'b0);
    repeat (3) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
